bcd_serial_addsub_seq: RTL and testbench

- Digit-serial sequencer for signed 3-digit BCD add/subtract.
- Sits directly upstream of the single-digit BCD add/subtract stage. It feeds that stage one digit pair per cycle, LSD first, and collects each result digit and carry.
- Performs 10's-complement subtraction and, when the raw result is negative, runs a second recomplement pass through the same digit stage.
- Returns a signed-magnitude result with valid/ready handshakes on both sides.

---
 rtl/bcd_serial_addsub_seq.sv | 136 +++++++++++++
 tb/tb_bcd_serial_addsub_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub_seq.sv
// Digit-serial signed-magnitude BCD add/subtract sequencer.
// It drives an external single-digit BCD stage one digit per cycle, least significant digit first.
module bcd_serial_addsub_seq #(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              op,
    input  logic              a_sign,
    input  logic [4*NDIG-1:0] a_mag,
    input  logic              b_sign,
    input  logic [4*NDIG-1:0] b_mag,
    output logic [3:0]        dig_a,
    output logic [3:0]        dig_b,
    output logic              dig_sub,
    output logic              dig_cin,
    input  logic [3:0]        dig_res,
    input  logic              dig_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_sign,
    output logic [4*NDIG-1:0] res_mag,
    output logic              res_ovf
);
    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q, r_q;
    logic            a_sign_q, eff_sub_q, carry_q, sign_q, ovf_q;
    logic [IW-1:0]   idx;
    logic            last;

    assign last      = (idx == IW'(NDIG - 1));
    assign res_valid = (state == DONE);
    assign res_mag   = r_q;
    assign res_ovf   = ovf_q;
    // A zero magnitude is always reported as positive.
    assign res_sign  = sign_q & (|r_q);

    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        dig_a       = 4'd0;
        dig_b       = 4'd0;
        dig_sub     = 1'b0;
        dig_cin     = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nx = PASS1;
            end
            PASS1: begin
                dig_a   = a_q[4*int'(idx) +: 4];
                dig_b   = b_q[4*int'(idx) +: 4];
                dig_sub = eff_sub_q;
                dig_cin = (idx == '0) ? eff_sub_q : carry_q;
                if (last) state_nx = (eff_sub_q && !dig_cout) ? PASS2 : DONE;
            end
            PASS2: begin
                // Recomplement: 0 - raw in 10's complement gives the true magnitude.
                dig_b   = r_q[4*int'(idx) +: 4];
                dig_sub = 1'b1;
                dig_cin = (idx == '0) ? 1'b1 : carry_q;
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            a_sign_q  <= 1'b0;
            eff_sub_q <= 1'b0;
            carry_q   <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            idx       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q       <= a_mag;
                        b_q       <= b_mag;
                        a_sign_q  <= a_sign;
                        eff_sub_q <= op ^ a_sign ^ b_sign;
                        r_q       <= '0;
                        carry_q   <= 1'b0;
                        sign_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        idx       <= '0;
                    end
                end
                PASS1: begin
                    r_q[4*int'(idx) +: 4] <= dig_res;
                    carry_q               <= dig_cout;
                    if (last) begin
                        idx <= '0;
                        if (!eff_sub_q) begin
                            ovf_q  <= dig_cout;
                            sign_q <= a_sign_q;
                        end else begin
                            ovf_q  <= 1'b0;
                            sign_q <= dig_cout ? a_sign_q : ~a_sign_q;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                PASS2: begin
                    r_q[4*int'(idx) +: 4] <= dig_res;
                    carry_q               <= dig_cout;
                    if (last) begin
                        idx   <= '0;
                        ovf_q <= 1'b0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_addsub_seq.sv
// Directed bench for bcd_serial_addsub_seq with a behavioural single-digit BCD stage.
module tb_bcd_serial_addsub_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0, start_ready;
    logic        op = 1'b0, a_sign = 1'b0, b_sign = 1'b0;
    logic [11:0] a_mag = '0, b_mag = '0;
    logic [3:0]  dig_a, dig_b, dig_res;
    logic        dig_sub, dig_cin, dig_cout;
    logic        res_valid, res_ready = 1'b0, res_sign, res_ovf;
    logic [11:0] res_mag;

    int checks = 0;
    int errors = 0;
    int cycles;
    logic [3:0] tr_b [0:31];
    logic       tr_s [0:31];

    always #5 clk = ~clk;

    // Digit stage: BCD(dig_a + (dig_sub ? 9-dig_b : dig_b) + dig_cin).
    always_comb begin
        int s;
        s = int'(dig_a) + (dig_sub ? (9 - int'(dig_b)) : int'(dig_b)) + int'(dig_cin);
        if (s > 9) begin
            dig_res  = 4'(s - 10);
            dig_cout = 1'b1;
        end else begin
            dig_res  = 4'(s);
            dig_cout = 1'b0;
        end
    end

    bcd_serial_addsub_seq #(.NDIG(3)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
        .dig_a(dig_a), .dig_b(dig_b), .dig_sub(dig_sub), .dig_cin(dig_cin),
        .dig_res(dig_res), .dig_cout(dig_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sign(res_sign), .res_mag(res_mag), .res_ovf(res_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, wait (bounded) for res_valid, check latency and result.
    task automatic run_op(input string tag, input logic o, input logic as, input logic [11:0] am,
                          input logic bs, input logic [11:0] bm, input int lat,
                          input logic es, input logic [11:0] em, input logic eo);
        @(negedge clk);
        chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
        op = o; a_sign = as; a_mag = am; b_sign = bs; b_mag = bm;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        cycles = 0;
        while (!res_valid && cycles < 20) begin
            tr_b[cycles] = dig_b;
            tr_s[cycles] = dig_sub;
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, ".latency"}, 32'(cycles), 32'(lat));
        chk({tag, ".sign"}, 32'(res_sign), 32'(es));
        chk({tag, ".mag"}, 32'(res_mag), 32'(em));
        chk({tag, ".ovf"}, 32'(res_ovf), 32'(eo));
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst.start_ready", 32'(start_ready), 32'd1);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.res", 32'({res_sign, res_ovf, res_mag}), 32'd0);
        chk("rst.dig", 32'({dig_a, dig_b, dig_sub, dig_cin}), 32'd0);
        #10 rst = 1'b0;

        run_op("add", 1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 3, 1'b0, 12'h579, 1'b0);
        release_res("add");

        run_op("sub_pos", 1'b1, 1'b0, 12'h456, 1'b0, 12'h123, 3, 1'b0, 12'h333, 1'b0);
        release_res("sub_pos");

        run_op("sub_neg", 1'b1, 1'b0, 12'h123, 1'b0, 12'h456, 6, 1'b1, 12'h333, 1'b0);
        chk("sub_neg.p1_b0", 32'(tr_b[0]), 32'h6);
        chk("sub_neg.p2_b0", 32'(tr_b[3]), 32'h7);
        chk("sub_neg.p2_b1", 32'(tr_b[4]), 32'h6);
        chk("sub_neg.p2_b2", 32'(tr_b[5]), 32'h6);
        chk("sub_neg.p2_sub", 32'({tr_s[3], tr_s[4], tr_s[5]}), 32'h7);
        release_res("sub_neg");

        run_op("ovf", 1'b0, 1'b0, 12'h999, 1'b0, 12'h001, 3, 1'b0, 12'h000, 1'b1);
        release_res("ovf");

        run_op("neg_add", 1'b0, 1'b1, 12'h123, 1'b0, 12'h456, 6, 1'b0, 12'h333, 1'b0);
        release_res("neg_add");

        run_op("zero", 1'b1, 1'b1, 12'h250, 1'b1, 12'h250, 3, 1'b0, 12'h000, 1'b0);
        release_res("zero");

        // Backpressure: result held while start_valid is presented and ignored.
        run_op("bp", 1'b1, 1'b0, 12'h100, 1'b0, 12'h250, 6, 1'b1, 12'h150, 1'b0);
        @(negedge clk);
        op = 1'b0; a_mag = 12'h777; b_mag = 12'h111; start_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp.valid", 32'(res_valid), 32'd1);
            chk("bp.start_ready", 32'(start_ready), 32'd0);
            chk("bp.res", 32'({res_sign, res_ovf, res_mag}), 32'({1'b1, 1'b0, 12'h150}));
        end
        start_valid = 1'b0;
        release_res("bp");

        // Reset in the middle of the recomplement pass.
        @(negedge clk);
        op = 1'b1; a_sign = 1'b0; a_mag = 12'h123; b_sign = 1'b0; b_mag = 12'h456;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("midrst.in_pass2", 32'(dig_sub), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst.start_ready", 32'(start_ready), 32'd1);
        chk("midrst.res_valid", 32'(res_valid), 32'd0);
        chk("midrst.res", 32'({res_sign, res_ovf, res_mag}), 32'd0);
        chk("midrst.dig", 32'({dig_a, dig_b, dig_sub, dig_cin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 1'b0, 1'b0, 12'h001, 1'b0, 12'h002, 3, 1'b0, 12'h003, 1'b0);
        release_res("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
